tdm_demux_5bit: RTL

Receive-side time-division demultiplexer. The transmit end alternates two 5-bit channels onto one 5-bit link using the 2:1 word mux. Channel 0 goes in slot 0 and is flagged with `sync`; channel 1 goes in slot 1. This block locks to `sync`, steers each accepted word back to its channel, and presents both channels as a registered pair. It also flags framing errors.

---
 rtl/tdm_demux_5bit_pkg.sv | 18 +
 rtl/tdm_demux_5bit_reg_en.sv | 27 ++
 rtl/tdm_demux_5bit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tdm_demux_5bit_pkg.sv
// Shared definitions for the receive-side TDM demultiplexer.
// The word width matches the transmit-side 2:1 word mux.
package tdm_demux_5bit_pkg;

  localparam int WIDTH = 5;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAIT0 = 2'd2
  } state_e;

  // Only WAIT1 leads to slot 1 being the next expected word.
  function automatic logic expects_slot1(input state_e st);
    return (st == ST_WAIT1);
  endfunction

endpackage

// File: rtl/tdm_demux_5bit_reg_en.sv
// WIDTH-bit enable register, asynchronously cleared to zero.
module reg_en_5bit #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Load on enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/tdm_demux_5bit.sv
// Two-channel TDM receiver: locks to sync, rebuilds channel pairs,
// and reports framing violations with a saturating counter.
module tdm_demux_5bit #(
  parameter int WIDTH = tdm_demux_5bit_pkg::WIDTH,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             out_valid,
  output logic             s0,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
);

  import tdm_demux_5bit_pkg::*;

  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             s0_q, locked_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             hold_en_s, pair_en_s;
  logic [WIDTH-1:0] hold0_s;

  // Next-state, pulse and register-enable decode for one accepted word.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    hold_en_s   = 1'b0;
    pair_en_s   = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (sync) begin
            hold_en_s = 1'b1;
            state_d   = ST_WAIT1;
          end else begin
            state_d   = ST_HUNT;
          end
        end
        ST_WAIT1: begin
          if (sync) begin
            // Slot 1 missing: the new slot-0 word restarts the frame.
            sync_err_d = 1'b1;
            hold_en_s  = 1'b1;
            state_d    = ST_WAIT1;
          end else begin
            pair_en_s   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_WAIT0;
          end
        end
        ST_WAIT0: begin
          if (sync) begin
            hold_en_s = 1'b1;
            state_d   = ST_WAIT1;
          end else begin
            sync_err_d = 1'b1;
            state_d    = ST_HUNT;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Saturating framing-error count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sync_err_d && (err_cnt_q != ErrMax)) begin
      err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      s0_q        <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= {ERR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      s0_q        <= expects_slot1(state_d);
      locked_q    <= (state_d == ST_WAIT1) || (state_d == ST_WAIT0);
      err_cnt_q   <= err_cnt_d;
    end
  end

  reg_en_5bit #(.WIDTH(WIDTH)) u_hold0 (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (hold_en_s),
    .d_i  (in),
    .q_o  (hold0_s)
  );

  reg_en_5bit #(.WIDTH(WIDTH)) u_out0 (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (pair_en_s),
    .d_i  (hold0_s),
    .q_o  (out0)
  );

  reg_en_5bit #(.WIDTH(WIDTH)) u_out1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (pair_en_s),
    .d_i  (in),
    .q_o  (out1)
  );

  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign s0        = s0_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;

endmodule
